// File: rtl/fault_pkg.sv
// Shared types, default sizes and helpers for the stuck-at fault campaign sequencer.
package fault_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StApply,
    StCheck,
    StLog,
    StAdvance,
    StDone
  } fault_state_e;

  // Field width for a counter that must hold values 0..n-1 (never narrower than 1 bit).
  function automatic int unsigned fld_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Coverage bitmap position of a node (1-based) and stuck value.
  function automatic int unsigned det_bit_idx(input int unsigned node, input logic stuck);
    return 2 * (node - 1) + 32'(stuck);
  endfunction

  localparam int unsigned DefNIn    = 5;
  localparam int unsigned DefNOut   = 2;
  localparam int unsigned DefNNodes = 16;
  localparam int unsigned DefNVec   = 16;
  localparam int unsigned DefSettle = 2;

  localparam int unsigned VecW  = fld_w(DefNVec);
  localparam int unsigned NodeW = fld_w(DefNNodes + 1);
  localparam int unsigned CntW  = fld_w(2 * DefNNodes + 1);

endpackage

// File: rtl/fault_cov_map.sv
// Per-fault coverage bitmap with a running count of distinct detected faults.
module fault_cov_map import fault_pkg::*; #(
  parameter int unsigned N_NODES = DefNNodes,
  localparam int unsigned DW     = 2 * N_NODES,
  localparam int unsigned CW     = fld_w(2 * N_NODES + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          set_i,
  input  logic [31:0]   idx_i,
  output logic [DW-1:0] detected_o,
  output logic [CW-1:0] det_cnt_o
);

  logic [DW-1:0] det_q, det_d, set_mask;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_new;

  always_comb begin
    set_mask = DW'(1) << idx_i;
    is_new   = ~|(det_q & set_mask);
    det_d    = det_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      det_d = '0;
      cnt_d = '0;
    end else if (set_i) begin
      det_d = det_q | set_mask;
      // Repeat detections of an already-covered fault leave the count alone.
      if (is_new) cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      det_q <= '0;
      cnt_q <= '0;
    end else begin
      det_q <= det_d;
      cnt_q <= cnt_d;
    end
  end

  assign detected_o = det_q;
  assign det_cnt_o  = cnt_q;

endmodule

// File: rtl/fault_campaign_ctrl.sv
// Stuck-at fault campaign sequencer: vector x node x stuck walk, compare, log, coverage.
// Optional FAULT_CAMPAIGN_DROP_EN skips combinations whose fault is already detected.
module fault_campaign_ctrl import fault_pkg::*; #(
  parameter int unsigned N_IN    = DefNIn,
  parameter int unsigned N_OUT   = DefNOut,
  parameter int unsigned N_NODES = DefNNodes,
  parameter int unsigned N_VEC   = DefNVec,
  parameter int unsigned SETTLE  = DefSettle,
  localparam int unsigned VW     = fld_w(N_VEC),
  localparam int unsigned NW     = fld_w(N_NODES + 1),
  localparam int unsigned DW     = 2 * N_NODES,
  localparam int unsigned CW     = fld_w(2 * N_NODES + 1),
  localparam int unsigned SW     = fld_w(SETTLE)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [VW-1:0]    vec_addr_o,
  input  logic [N_IN-1:0]  vec_data_i,
  output logic [N_IN-1:0]  dut_in_o,
  output logic [NW-1:0]    fault_sel_o,
  output logic             fault_val_o,
  input  logic [N_OUT-1:0] dut_out_i,
  input  logic [N_OUT-1:0] gold_out_i,
  output logic             log_valid_o,
  input  logic             log_ready_i,
  output logic [VW-1:0]    log_vec_o,
  output logic [NW-1:0]    log_node_o,
  output logic             log_stuck_o,
  output logic [DW-1:0]    detected_o,
  output logic [CW-1:0]    det_cnt_o
);

  fault_state_e    state_q, state_d;
  logic [VW-1:0]   vec_q, vec_d, nxt_vec;
  logic [NW-1:0]   node_q, node_d, nxt_node;
  logic            stuck_q, stuck_d, nxt_stuck;
  logic [SW-1:0]   settle_q, settle_d;
  logic [N_IN-1:0] dut_in_q, dut_in_d;
  logic            wrap_vec, last_combo;
  logic            cov_clear, cov_set;
  logic [31:0]     cur_idx;
  logic            fault_phase;

  assign cur_idx = det_bit_idx(32'(node_q), stuck_q);

  fault_cov_map #(
    .N_NODES (N_NODES)
  ) u_cov_map (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (cov_clear),
    .set_i      (cov_set),
    .idx_i      (cur_idx),
    .detected_o (detected_o),
    .det_cnt_o  (det_cnt_o)
  );

  // Successor of the current combination: stuck inner, node middle, vector outer.
  always_comb begin
    nxt_vec    = vec_q;
    nxt_node   = node_q;
    nxt_stuck  = ~stuck_q;
    wrap_vec   = 1'b0;
    last_combo = 1'b0;
    if (stuck_q) begin
      nxt_stuck = 1'b0;
      if (node_q == NW'(N_NODES)) begin
        nxt_node = NW'(1);
        wrap_vec = 1'b1;
        if (vec_q == VW'(N_VEC - 1)) last_combo = 1'b1;
        else nxt_vec = vec_q + VW'(1);
      end else begin
        nxt_node = node_q + NW'(1);
      end
    end
  end

`ifdef FAULT_CAMPAIGN_DROP_EN
  logic cur_hit, nxt_hit;
  assign cur_hit = |(detected_o & (DW'(1) << cur_idx));
  assign nxt_hit = |(detected_o & (DW'(1) << det_bit_idx(32'(nxt_node), nxt_stuck)));
`endif

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    node_d    = node_q;
    stuck_d   = stuck_q;
    settle_d  = settle_q;
    dut_in_d  = dut_in_q;
    cov_clear = 1'b0;
    cov_set   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StFetch;
          vec_d     = '0;
          node_d    = NW'(1);
          stuck_d   = 1'b0;
          settle_d  = '0;
          cov_clear = 1'b1;
        end
      end
      StFetch: begin
        dut_in_d = vec_data_i;
        settle_d = '0;
`ifdef FAULT_CAMPAIGN_DROP_EN
        state_d  = cur_hit ? StAdvance : StApply;
`else
        state_d  = StApply;
`endif
      end
      StApply: begin
        if (settle_q == SW'(SETTLE - 1)) state_d = StCheck;
        else settle_d = settle_q + SW'(1);
      end
      StCheck: begin
        if (dut_out_i != gold_out_i) begin
          cov_set = 1'b1;
          state_d = StLog;
        end else begin
          state_d = StAdvance;
        end
      end
      StLog: begin
        if (log_ready_i) state_d = StAdvance;
      end
      StAdvance: begin
        settle_d = '0;
        if (last_combo) begin
          state_d = StDone;
        end else begin
          vec_d   = nxt_vec;
          node_d  = nxt_node;
          stuck_d = nxt_stuck;
          if (wrap_vec) begin
            state_d = StFetch;
          end else begin
`ifdef FAULT_CAMPAIGN_DROP_EN
            // A covered combination costs one ADVANCE cycle and is never applied.
            state_d = nxt_hit ? StAdvance : StApply;
`else
            state_d = StApply;
`endif
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      vec_q    <= '0;
      node_q   <= '0;
      stuck_q  <= 1'b0;
      settle_q <= '0;
      dut_in_q <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      node_q   <= node_d;
      stuck_q  <= stuck_d;
      settle_q <= settle_d;
      dut_in_q <= dut_in_d;
    end
  end

  assign fault_phase = (state_q == StApply) || (state_q == StCheck) || (state_q == StLog);

  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign vec_addr_o  = vec_q;
  assign dut_in_o    = dut_in_q;
  assign fault_sel_o = fault_phase ? node_q : '0;
  assign fault_val_o = fault_phase & stuck_q;
  assign log_valid_o = (state_q == StLog);
  assign log_vec_o   = log_valid_o ? vec_q : '0;
  assign log_node_o  = log_valid_o ? node_q : '0;
  assign log_stuck_o = log_valid_o & stuck_q;

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Directed bench for fault_campaign_ctrl; expectations follow FAULT_CAMPAIGN_DROP_EN.
module tb_fault_campaign_ctrl;
  import fault_pkg::*;

`ifdef FAULT_CAMPAIGN_DROP_EN
  localparam bit DropEn = 1'b1;
`else
  localparam bit DropEn = 1'b0;
`endif

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic                  start_i = 1'b0;
  logic                  busy_o, done_o;
  logic [VecW-1:0]       vec_addr_o;
  logic [DefNIn-1:0]     vec_data_i;
  logic [DefNIn-1:0]     dut_in_o;
  logic [NodeW-1:0]      fault_sel_o;
  logic                  fault_val_o;
  logic [DefNOut-1:0]    dut_out_i, gold_out_i, flip;
  logic                  log_valid_o;
  logic                  log_ready_i = 1'b1;
  logic [VecW-1:0]       log_vec_o;
  logic [NodeW-1:0]      log_node_o;
  logic                  log_stuck_o;
  logic [2*DefNNodes-1:0] detected_o;
  logic [CntW-1:0]       det_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  // Scenario and monitor state
  int cur_mode = 0;
  int bp_req   = 0;
  int bp_used  = 0;
  int rec_cnt  = 0;
  logic [VecW-1:0]  rec_vec, held_vec;
  logic [NodeW-1:0] rec_node, held_node;
  logic             rec_stuck, held_stuck;
  bit               pend = 1'b0;

  always #5 clk_i = ~clk_i;

  fault_campaign_ctrl #(
    .N_IN    (DefNIn),
    .N_OUT   (DefNOut),
    .N_NODES (DefNNodes),
    .N_VEC   (DefNVec),
    .SETTLE  (DefSettle)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .vec_addr_o  (vec_addr_o),
    .vec_data_i  (vec_data_i),
    .dut_in_o    (dut_in_o),
    .fault_sel_o (fault_sel_o),
    .fault_val_o (fault_val_o),
    .dut_out_i   (dut_out_i),
    .gold_out_i  (gold_out_i),
    .log_valid_o (log_valid_o),
    .log_ready_i (log_ready_i),
    .log_vec_o   (log_vec_o),
    .log_node_o  (log_node_o),
    .log_stuck_o (log_stuck_o),
    .detected_o  (detected_o),
    .det_cnt_o   (det_cnt_o)
  );

  function automatic logic [DefNIn-1:0] rom_word(input int v);
    return 5'(v) ^ 5'h15;
  endfunction

  assign vec_data_i = rom_word(int'(vec_addr_o));

  // Circuit model: mode 1 = node 3 sa1 visible on vector 5 only,
  // mode 2 = node 7 sa0 visible on vectors 2 and 9.
  always_comb begin
    gold_out_i = dut_in_o[1:0] ^ dut_in_o[4:3];
    flip = '0;
    if (cur_mode == 1 && fault_sel_o == 3 && fault_val_o && dut_in_o == rom_word(5))
      flip = 2'b01;
    if (cur_mode == 2 && fault_sel_o == 7 && !fault_val_o &&
        (dut_in_o == rom_word(2) || dut_in_o == rom_word(9)))
      flip = 2'b10;
    dut_out_i = gold_out_i ^ flip;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Log consumer: drives backpressure, counts accepted records, checks record stability.
  always @(negedge clk_i) begin
    if (rst_i) begin
      pend = 1'b0;
    end else if (start_i && !busy_o) begin
      bp_used = 0;
      rec_cnt = 0;
      pend    = 1'b0;
    end
    if (log_valid_o && bp_used < bp_req) begin
      log_ready_i = 1'b0;
      bp_used++;
    end else begin
      log_ready_i = 1'b1;
    end
    if (log_valid_o) begin
      if (pend)
        check("log_record_stable", {log_vec_o, log_node_o, log_stuck_o},
              {held_vec, held_node, held_stuck});
      if (log_ready_i) begin
        if (rec_cnt == 0) begin
          rec_vec   = log_vec_o;
          rec_node  = log_node_o;
          rec_stuck = log_stuck_o;
        end
        rec_cnt++;
        pend = 1'b0;
      end else begin
        held_vec   = log_vec_o;
        held_node  = log_node_o;
        held_stuck = log_stuck_o;
        pend       = 1'b1;
      end
    end else if (pend && !rst_i) begin
      check("log_valid_held", 64'(log_valid_o), 64'd1);
      pend = 1'b0;
    end
  end

  // Returns the number of edges from the one sampling start to the first with done high.
  task automatic run_campaign(input int mode, input int bp, input bit restart, output int cycles);
    cur_mode = mode;
    bp_req   = bp;
    cycles   = 0;
    start_i  = 1'b1;
    for (int c = 1; c <= 5000; c++) begin
      @(posedge clk_i);
      #1;
      start_i = restart && (c == 100);
      if (done_o) begin
        cycles = c;
        break;
      end
    end
  endtask

  typedef struct {
    string       name;
    int          mode;
    int          bp;
    bit          restart;
    int          exp_cycles;
    int          exp_recs;
    int          exp_cnt;
    logic [31:0] exp_det;
    int          exp_vec;
    int          exp_node;
    int          exp_stuck;
  } row_t;

  row_t rows[5];
  int   cyc;

  initial begin
    rows[0] = '{"fault_free", 0, 0, 1'b0, 2065, 0, 0, 32'h0, 0, 0, 0};
    rows[1] = '{"n3_sa1_v5", 1, 0, 1'b0, DropEn ? 2036 : 2066, 1, 1, 32'h20, 5, 3, 1};
    rows[2] = '{"n3_sa1_bp10", 1, 10, 1'b0, DropEn ? 2046 : 2076, 1, 1, 32'h20, 5, 3, 1};
    rows[3] = '{"n7_sa0_v2_v9", 2, 0, 1'b0, DropEn ? 2027 : 2067, DropEn ? 1 : 2, 1,
                32'h1000, 2, 7, 0};
    rows[4] = '{"restart_busy", 0, 0, 1'b1, 2065, 0, 0, 32'h0, 0, 0, 0};

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_busy_done", {busy_o, done_o, log_valid_o}, 3'b000);
    check("rst_vec_in", {vec_addr_o, dut_in_o}, '0);
    check("rst_fault", {fault_sel_o, fault_val_o}, '0);
    check("rst_log_fields", {log_vec_o, log_node_o, log_stuck_o}, '0);
    check("rst_cov", {detected_o, det_cnt_o}, '0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 5; i++) begin
      run_campaign(rows[i].mode, rows[i].bp, rows[i].restart, cyc);
      check({rows[i].name, "_cycles"}, 64'(cyc), 64'(rows[i].exp_cycles));
      @(posedge clk_i);
      #1;
      check({rows[i].name, "_done_pulse"}, {done_o, busy_o}, 2'b00);
      repeat (3) @(posedge clk_i);
      #1;
      check({rows[i].name, "_records"}, 64'(rec_cnt), 64'(rows[i].exp_recs));
      check({rows[i].name, "_det_cnt"}, 64'(det_cnt_o), 64'(rows[i].exp_cnt));
      check({rows[i].name, "_detected"}, 64'(detected_o), 64'(rows[i].exp_det));
      if (rows[i].exp_recs > 0)
        check({rows[i].name, "_first_record"}, {rec_vec, rec_node, rec_stuck},
              {4'(rows[i].exp_vec), 5'(rows[i].exp_node), 1'(rows[i].exp_stuck)});
    end

    // Reset in the middle of vector 8 abandons the campaign and clears coverage.
    cur_mode = 1;
    bp_req   = 0;
    start_i  = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (vec_addr_o == 8) break;
      @(posedge clk_i);
      #1;
    end
    check("mid_reach_vec8", 64'(vec_addr_o), 64'd8);
    repeat (20) @(posedge clk_i);
    #1;
    check("mid_pre_rst_detected", 64'(detected_o), 64'h20);
    check("mid_pre_rst_dut_in", 64'(dut_in_o), 64'(rom_word(8)));
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("mid_rst_status", {busy_o, done_o, log_valid_o}, 3'b000);
    check("mid_rst_vec_in", {vec_addr_o, dut_in_o}, '0);
    check("mid_rst_fault", {fault_sel_o, fault_val_o}, '0);
    check("mid_rst_cov", {detected_o, det_cnt_o}, '0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    run_campaign(1, 0, 1'b0, cyc);
    check("post_rst_cycles", 64'(cyc), DropEn ? 64'd2036 : 64'd2066);
    repeat (2) @(posedge clk_i);
    #1;
    check("post_rst_record", {rec_vec, rec_node, rec_stuck}, {4'd5, 5'd3, 1'b1});
    check("post_rst_cov", {detected_o, det_cnt_o}, {32'h20, 6'd1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fault_campaign_ctrl.md
# fault_campaign_ctrl

Hardware sequencer for stuck-at fault-injection campaigns. It walks every test vector, fault node and stuck value, and drives the fault-select and stuck-value inputs of the fault-injectable circuit. It compares the faulty outputs against the golden-model outputs, logs each detection and keeps a per-fault coverage bitmap. It sits between a vector ROM and the fault-injected top-level/golden pair, and replaces the software loop in the simulation benches.

## Interface

Parameters:
- N_IN, 5, width of a test vector / circuit input bus
- N_OUT, 2, width of circuit output bus
- N_NODES, 16, number of injectable nodes, numbered 1..N_NODES (select 0 = fault-free)
- N_VEC, 16, number of vectors in the ROM
- SETTLE, 2, cycles a fault/vector is held before compare (≥1)

Ports:
- clk, in, 1, single clock
- rst, in, 1, synchronous, active-high reset
- start, in, 1, single-cycle campaign start; ignored while busy
- busy, out, 1, campaign running
- done, out, 1, one-cycle pulse at campaign end
- vec_addr, out, clog2(N_VEC), ROM address
- vec_data, in, N_IN, ROM data, valid one cycle after vec_addr
- dut_in, out, N_IN, vector driven to both faulty and golden circuits
- fault_sel, out, clog2(N_NODES+1), node select; 0 = no fault
- fault_val, out, 1, stuck value (0 = sa0, 1 = sa1)
- dut_out, in, N_OUT, faulty-circuit outputs
- gold_out, in, N_OUT, golden-circuit outputs
- log_valid, out, 1, detection record available
- log_ready, in, 1, consumer accepts record
- log_vec / log_node / log_stuck, out, clog2(N_VEC) / clog2(N_NODES+1) / 1, detection record
- detected, out, 2*N_NODES, coverage bitmap; bit 2*(node-1)+stuck
- det_cnt, out, clog2(2*N_NODES+1), number of set bits in detected

## Operation

- Loop order: vector outer (0..N_VEC-1), node middle (1..N_NODES), stuck inner (0 then 1).
- States:
  - IDLE: go to FETCH on start. Clear detected and det_cnt, and reset all counters.
  - FETCH: vec_addr is valid. Latch vec_data into dut_in on the next edge, then go to APPLY.
  - APPLY: drive fault_sel/fault_val and hold them for SETTLE cycles (settle counter), then go to CHECK.
  - CHECK: compare dut_out to gold_out.
    - Mismatch: set the detected bit (det_cnt += 1 only if the bit was previously clear) and go to LOG.
    - Match: go to ADVANCE.
  - LOG: hold log_valid=1 and a stable record until log_ready, then go to ADVANCE.
  - ADVANCE: step stuck → node → vector.
    - Next vector: go to FETCH.
    - All vectors exhausted: go to DONE.
    - Otherwise: go to APPLY.
  - DONE: done=1 for one cycle, then go to IDLE.
- Logging rules:
  - A fault that was already detected is logged again on every later vector that detects it.
  - detected and det_cnt hold after DONE until the next start.
- Outside APPLY/CHECK/LOG, fault_sel=0 and fault_val=0.
- start is ignored while busy.
- busy=1 in all states except IDLE.

## Timing

- Reset values: all outputs 0, state IDLE. This applies to reset asserted mid-campaign too: the campaign is abandoned, and detected and det_cnt are cleared.
- Latency without mismatches or dropping:
  - Per combination: SETTLE + 2 cycles (APPLY, CHECK, ADVANCE).
  - Per vector: 1 FETCH cycle plus the combinations.
  - Total from start to done pulse: N_VEC·(1 + 2·N_NODES·(SETTLE+2)) + 1 cycles.
  - Defaults: 16·(1+32·4)+1 = 2065 cycles.
- Each mismatch adds LOG cycles: 1 with log_ready held high, more under backpressure.
- log_valid rises the cycle after CHECK and falls the cycle after the valid&&ready handshake.
- log_valid must not drop, and the record must not change, before acceptance.
- dut_in changes only on the FETCH→APPLY edge. fault_sel/fault_val change only on entry to APPLY.

## Configuration

- FAULT_CAMPAIGN_DROP_EN
  - Defined: fault dropping. In ADVANCE, a combination whose detected bit is already set is skipped in one cycle, with no APPLY, no CHECK and no log.
  - Undefined: every combination is applied; the behaviour above is exact.
  - det_cnt and detected are identical at DONE in both builds.

## Structure

- Shared package fault_pkg holds:
  - state enum (IDLE, FETCH, APPLY, CHECK, LOG, ADVANCE, DONE);
  - width localparams for node, vector and count fields;
  - the bit-index function node/stuck → detected bit.
- One sub-module fault_cov_map: the detected register, set-on-detect, clear-on-start, and the det_cnt increment-on-new-bit logic.

## Test plan

- Fault-free circuit (dut_out tied to gold_out), defaults, SETTLE=2: start → done pulse exactly 2065 cycles later, log_valid never asserted, det_cnt=0.
- Circuit model where node 3 sa1 mismatches only on vector 5:
  - log record (vec=5, node=3, stuck=1);
  - detected bit 5 set;
  - det_cnt=1;
  - done at 2066 cycles.
- Same circuit with log_ready held low for 10 cycles on that record: log fields stable for those cycles, done delayed by 10 cycles, still exactly one record.
- Node 7 sa0 detected on vectors 2 and 9:
  - without FAULT_CAMPAIGN_DROP_EN: two records, det_cnt=1;
  - with it: one record (vec 2), det_cnt=1, and the skip at vector 9 costs 1 cycle instead of 4.
- rst asserted in the middle of vector 8: next cycle all outputs 0, state IDLE, detected=0. A new start runs a full campaign from vector 0.
- start pulsed again while busy: no effect on counters or on done timing.
